relu_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one registered RELU datapath among NREQ requesters. Each requester presents a W-bit signed operand with a level request. The block grants one requester at a time and captures its operand. The following cycle it returns the rectified result, tagged with the requester ID. It sits between the per-neuron accumulators and the single activation unit, and also keeps a saturating count of clipped (negative) operands.

---
 rtl/relu_arb_pkg.sv | 7 +
 rtl/relu_share_arb_rr_pick.sv | 21 ++
 rtl/relu_share_arb.sv | 55 +++++
 tb/tb_relu_share_arb.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/relu_arb_pkg.sv
// relu_arb_pkg: FSM state enum, default NREQ/W and the clip counter ceiling
package relu_arb_pkg;
  typedef enum logic {ARB, HOLD} state_t;
  localparam int NREQ_DEF = 4;
  localparam int W_DEF = 4;
  localparam logic [7:0] CLIP_MAX = 8'd255;
endpackage

// File: rtl/relu_share_arb_rr_pick.sv
// rr_pick: combinational round-robin picker; req/ptr in, win (first set req at or above ptr, wrapping) and any out
module rr_pick #(
  parameter int N = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] win,
  output logic           any
);
  logic [IDW-1:0] j;
  always_comb begin
    win = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr) + k) % N);
      win = req[j] ? j : win;
    end
  end
  assign any = |req;
endmodule

// File: rtl/relu_share_arb.sv
// relu_share_arb: round-robin shared RELU unit; clk/rst_n/en/req/din/clr_cnt in, gnt/dout/dout_vld/dout_id/clip_cnt out
module relu_share_arb
  import relu_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W = W_DEF,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] din,
  input  logic              clr_cnt,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      dout,
  output logic              dout_vld,
  output logic [IDW-1:0]    dout_id,
  output logic [7:0]        clip_cnt
);
  state_t state, state_nx;
  logic [IDW-1:0] ptr, win, id;
  logic [W-1:0] op;
  logic any, take;
  rr_pick #(.N(NREQ), .IDW(IDW)) u_pick (
    .req(req),
    .ptr(ptr),
    .win(win),
    .any(any)
  );
  always_comb begin
    take = (state == ARB) && en && any;
    state_nx = take ? HOLD : ARB;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ARB;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      op <= '0;
      id <= '0;
      gnt <= '0;
      clip_cnt <= '0;
    end else begin
      gnt <= take ? NREQ'(1) << win : '0;
      ptr <= !take ? ptr : (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
      op <= take ? din[int'(win)*W +: W] : op;
      id <= take ? win : id;
      clip_cnt <= clr_cnt ? '0 : (state == HOLD && op[W-1] && clip_cnt != CLIP_MAX) ? clip_cnt + 8'd1 : clip_cnt;
    end
  assign dout = op[W-1] ? '0 : op;
  assign dout_vld = state == HOLD;
  assign dout_id = id;
endmodule

// File: tb/tb_relu_share_arb.sv
// tb_relu_share_arb: directed scoreboard bench for relu_share_arb
module tb_relu_share_arb;
  logic clk = 0, rst_n = 0, en = 0, clr_cnt = 0;
  logic [3:0] req = '0;
  logic [15:0] din = '0;
  logic [3:0] gnt, dout;
  logic dout_vld;
  logic [1:0] dout_id;
  logic [7:0] clip_cnt;
  typedef struct packed {logic [1:0] id; logic [3:0] d;} exp_t;
  exp_t q[$];
  exp_t e;
  int pass = 0, total = 0;
  relu_share_arb #(.NREQ(4), .W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .req(req),
    .din(din),
    .clr_cnt(clr_cnt),
    .gnt(gnt),
    .dout(dout),
    .dout_vld(dout_vld),
    .dout_id(dout_id),
    .clip_cnt(clip_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [1:0] id, input logic [3:0] d);
    q.push_back(exp_t'({id, d}));
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (dout_vld) begin
        if (q.size() == 0) chk("unexpected_result", q.size(), 1);
        else begin
          e = q.pop_front();
          chk("dout_id", dout_id, e.id);
          chk("dout", dout, e.d);
          chk("gnt", gnt, 4'b0001 << e.id);
        end
      end else chk("gnt_idle", gnt, 0);
    end
  initial begin
    cyc(2);
    chk("rst_gnt", gnt, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_id", dout_id, 0);
    chk("rst_clip", clip_cnt, 0);
    rst_n = 1;
    en = 1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_vld", dout_vld, 0);
      chk("idle_clip", clip_cnt, 0);
    end
    cyc(1);
    req = 4'b0001;
    din[3:0] = 4'b0101;
    push(0, 4'b0101);
    cyc(1);
    req = '0;
    cyc(2);
    chk("single_clip", clip_cnt, 0);
    rst_n = 0;
    #2;
    rst_n = 1;
    din = {4'b0001, 4'b1111, 4'b1001, 4'b0101};
    req = 4'b1111;
    push(0, 4'b0101);
    push(1, 4'b0000);
    push(2, 4'b0000);
    push(3, 4'b0001);
    push(0, 4'b0101);
    cyc(9);
    req = '0;
    cyc(2);
    chk("round_clip", clip_cnt, 2);
    din[7:4] = 4'b0011;
    req = 4'b0010;
    push(1, 4'b0011);
    cyc(1);
    req = '0;
    cyc(1);
    din[3:0] = 4'b0111;
    din[7:4] = 4'b1000;
    req = 4'b0011;
    push(0, 4'b0111);
    push(1, 4'b0000);
    cyc(1);
    req = 4'b0010;
    cyc(2);
    en = 0;
    req = 4'b0011;
    cyc(1);
    repeat (4) begin
      @(negedge clk);
      chk("en_off_gnt", gnt, 0);
      chk("en_off_vld", dout_vld, 0);
    end
    chk("en_off_clip", clip_cnt, 3);
    req = '0;
    en = 1;
    cyc(1);
    din[15:12] = 4'b1000;
    req = 4'b1000;
    for (int i = 0; i < 260; i++) push(3, 4'b0000);
    cyc(519);
    req = '0;
    cyc(1);
    chk("sat_clip", clip_cnt, 255);
    req = 4'b1000;
    push(3, 4'b0000);
    cyc(1);
    req = '0;
    clr_cnt = 1;
    cyc(1);
    clr_cnt = 0;
    chk("clr_clip", clip_cnt, 0);
    din[7:4] = 4'b0011;
    req = 4'b0010;
    cyc(1);
    chk("pre_rst_gnt", gnt, 4'b0010);
    chk("pre_rst_dout", dout, 4'b0011);
    rst_n = 0;
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_vld", dout_vld, 0);
    chk("async_dout", dout, 0);
    chk("async_id", dout_id, 0);
    #2;
    rst_n = 1;
    din[7:4] = 4'b0111;
    din[11:8] = 4'b0101;
    req = 4'b0110;
    push(1, 4'b0111);
    cyc(1);
    req = '0;
    cyc(3);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
